dmem_lsu: RTL and testbench

//  Load/store unit downstream of the pipelined RV32i core's MEM stage. Consumes address, store data, mem_w/mem_r
//  and size/sign controls; drives a req/ack data-memory bus with byte enables. Returns aligned, sign/zero-

---
 rtl/rv32_mem_pkg.sv | 19 +
 rtl/lsu_align.sv | 39 +++
 rtl/dmem_lsu.sv | 127 ++++++++++++
 tb/tb_dmem_lsu.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared size encodings, LSU state type and alignment rule for the RV32 data-memory path.
package rv32_mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // Encoding 2'b11 behaves as a word, so any size with bit 1 set needs word alignment.
  function automatic logic misaligned_acc(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SZ_H) && lo[0]) || (size[1] && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables and replicated store data, plus load extraction and extension.
module lsu_align
  import rv32_mem_pkg::*;
(
  input  logic [1:0]  lo,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_byte    = rdata[{lo, 3'b000} +: 8];
    rd_half    = rdata[{lo[1], 4'b0000} +: 16];
    be         = 4'b1111;
    lane_wdata = wdata;
    load_data  = rdata;
    case (size)
      SZ_B: begin
        be         = 4'b0001 << lo;
        lane_wdata = {4{wdata[7:0]}};
        load_data  = {{24{sign & rd_byte[7]}}, rd_byte};
      end
      SZ_H: begin
        be         = 4'b0011 << {lo[1], 1'b0};
        lane_wdata = {2{wdata[15:0]}};
        load_data  = {{16{sign & rd_half[15]}}, rd_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: one req/ack bus access per MEM-stage request, stalling the core until it completes.
// Minimum two stall cycles; a silent bus is abandoned after TIMEOUT_CYC cycles with a bus_err pulse.
module dmem_lsu
  import rv32_mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_w,
  input  logic        mem_r,
  input  logic [1:0]  B_H_W,
  input  logic        sign,
  output logic [31:0] data_in,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       lo_q;
  logic [1:0]       size_q;
  logic             sign_q;

  logic        req;
  logic        misal;
  logic        accept;
  logic [1:0]  lo_s;
  logic [1:0]  size_s;
  logic        sign_s;
  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic [31:0] ld_c;

  assign req    = mem_w | mem_r;
  assign misal  = misaligned_acc(B_H_W, addr[1:0]);
  assign accept = (state == IDLE) && req && !misal;
  // Reset must release the pipeline at once, even if a request is still presented.
  assign stall  = rst && (accept || (state == BUS));

  // Live controls while deciding in IDLE; the captured copy while the access is in flight.
  assign lo_s   = (state == IDLE) ? addr[1:0] : lo_q;
  assign size_s = (state == IDLE) ? B_H_W     : size_q;
  assign sign_s = (state == IDLE) ? sign      : sign_q;

  lsu_align u_align (
    .lo         (lo_s),
    .size       (size_s),
    .sign       (sign_s),
    .wdata      (wdata),
    .rdata      (bus_rdata),
    .be         (be_c),
    .lane_wdata (wd_c),
    .load_data  (ld_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lo_q       <= 2'b00;
      size_q     <= 2'b00;
      sign_q     <= 1'b0;
      data_in    <= '0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
    end else begin
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (misal) begin
              misaligned <= 1'b1;
            end else begin
              bus_req   <= 1'b1;
              bus_we    <= mem_w;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_be    <= mem_w ? be_c : 4'b1111;
              bus_wdata <= wd_c;
              lo_q      <= addr[1:0];
              size_q    <= B_H_W;
              sign_q    <= sign;
              cnt       <= '0;
              state     <= BUS;
            end
          end
        end
        BUS: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            if (!bus_we) data_in <= ld_c;
            state   <= DONE;
          end else if (cnt == CNT_LAST) begin
            bus_req <= 1'b0;
            bus_err <= 1'b1;
            if (!bus_we) data_in <= '0;
            state   <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed and randomized checks of dmem_lsu against a transaction-level reference model.
module tb_dmem_lsu;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_w;
  logic        mem_r;
  logic [1:0]  B_H_W;
  logic        sign;
  logic [31:0] data_in;
  logic        stall;
  logic        misaligned;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mdl_data = '0;

  dmem_lsu #(.TIMEOUT_CYC(TO), .CNT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .wdata      (wdata),
    .mem_w      (mem_w),
    .mem_r      (mem_r),
    .B_H_W      (B_H_W),
    .sign       (sign),
    .data_in    (data_in),
    .stall      (stall),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [31:0] rd,
                                           input logic [1:0] sz, input bit sg);
    logic [31:0] v;
    int lo;
    lo = int'(a % 4);
    if (sz == 2'd0) begin
      v = (rd >> (8 * lo)) % 256;
      if (sg && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (rd >> (16 * (lo / 2))) % 65536;
      if (sg && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_be(input logic [31:0] a, input logic [1:0] sz);
    int lo;
    lo = int'(a % 4);
    if (sz == 2'd0) return 32'(1 << lo);
    if (sz == 2'd1) return 32'(3 << ((lo / 2) * 2));
    return 32'd15;
  endfunction

  function automatic logic [31:0] ref_wd(input logic [31:0] w, input logic [1:0] sz);
    if (sz == 2'd0) return (w % 256) * 32'h0101_0101;
    if (sz == 2'd1) return (w % 65536) * 32'h0001_0001;
    return w;
  endfunction

  // d = BUS cycles without ack before ack arrives; d >= TO means the bus never answers.
  task automatic run_op(input logic [31:0] a, input logic [31:0] wd, input bit w, input bit r,
                        input logic [1:0] sz, input bit sg, input int d, input logic [31:0] rd,
                        input bit keep);
    bit mis;
    bit to;
    int nbus;
    int nst;
    @(negedge clk);
    addr = a; wdata = wd; mem_w = w; mem_r = r; B_H_W = sz; sign = sg; bus_ack = 1'b0;
    mis = ((sz == 2'd1) && (a % 2 != 0)) || ((sz >= 2'd2) && (a % 4 != 0));
    #1;
    if (mis) begin
      chk("mis_stall", stall, 0);
      @(negedge clk);
      mem_w = 1'b0; mem_r = 1'b0;
      chk("mis_pulse", misaligned, 1);
      chk("mis_no_req", bus_req, 0);
      chk("mis_data_kept", data_in, mdl_data);
      #1 chk("mis_stall2", stall, 0);
      @(negedge clk);
      chk("mis_pulse_end", misaligned, 0);
      chk("mis_no_req2", bus_req, 0);
      return;
    end
    chk("idle_stall", stall, 1);
    nst  = 1;
    to   = (d >= TO);
    nbus = to ? TO : d + 1;
    for (int k = 0; k < nbus; k++) begin
      @(negedge clk);
      if (stall) nst++;
      chk("bus_req", bus_req, 1);
      chk("bus_addr", bus_addr, a & 32'hFFFF_FFFC);
      chk("bus_we", bus_we, w);
      chk("bus_be", bus_be, w ? ref_be(a, sz) : 32'd15);
      if (w) chk("bus_wdata", bus_wdata, ref_wd(wd, sz));
      bus_ack   = !to && (k == d);
      bus_rdata = bus_ack ? rd : $urandom;
    end
    @(negedge clk);
    bus_ack = 1'b0;
    if (!keep) begin
      mem_w = 1'b0; mem_r = 1'b0;
    end
    if (!w) mdl_data = to ? 32'd0 : ref_load(a, rd, sz, sg);
    chk("done_req", bus_req, 0);
    chk("done_stall", stall, 0);
    chk("bus_err", bus_err, to);
    chk("data_in", data_in, mdl_data);
    chk("stall_cycles", nst, 1 + nbus);
  endtask

  initial begin
    rst = 1'b0; addr = '0; wdata = '0; mem_w = 1'b0; mem_r = 1'b0;
    B_H_W = 2'b00; sign = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", bus_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_mis", misaligned, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_data", data_in, 0);
    chk("rst_addr", bus_addr, 0);
    chk("rst_be", bus_be, 0);
    chk("rst_wdata", bus_wdata, 0);
    rst = 1'b1;

    // Byte store, ack on third BUS cycle.
    run_op(32'h103, 32'h0000_00AB, 1, 0, 2'b00, 0, 2, 32'h0, 0);
    // Signed then unsigned half load, immediate ack.
    run_op(32'h202, 32'h0, 0, 1, 2'b01, 1, 0, 32'h8001_1234, 0);
    chk("half_signed", data_in, 32'hFFFF_8001);
    run_op(32'h202, 32'h0, 0, 1, 2'b01, 0, 0, 32'h8001_1234, 0);
    chk("half_unsigned", data_in, 32'h0000_8001);
    // Misaligned word load.
    run_op(32'h006, 32'h0, 0, 1, 2'b10, 0, 0, 32'h0, 0);
    // Silent bus, then ack arriving on the last allowed cycle.
    run_op(32'h400, 32'h0, 0, 1, 2'b10, 0, TO, 32'h0, 0);
    @(negedge clk);
    chk("err_pulse_end", bus_err, 0);
    run_op(32'h404, 32'h0, 0, 1, 2'b10, 0, TO - 1, 32'h1357_9BDF, 0);
    // Both strobes: store wins.
    run_op(32'h010, 32'hDEAD_BEEF, 1, 1, 2'b10, 0, 1, 32'h0, 0);
    // Back-to-back loads with the request held through DONE.
    run_op(32'h020, 32'h0, 0, 1, 2'b10, 0, 0, 32'hCAFE_F00D, 1);
    run_op(32'h020, 32'h0, 0, 1, 2'b10, 0, 1, 32'h0BAD_CAFE, 0);

    // Reset in the middle of an access.
    @(negedge clk);
    addr = 32'h300; mem_r = 1'b1; mem_w = 1'b0; B_H_W = 2'b10; sign = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_req", bus_req, 1);
    rst = 1'b0; mem_r = 1'b0;
    mdl_data = 32'd0;
    #1;
    chk("midrst_req", bus_req, 0);
    chk("midrst_stall", stall, 0);
    chk("midrst_data", data_in, 0);
    @(negedge clk);
    rst = 1'b1;
    run_op(32'h304, 32'h0, 0, 1, 2'b00, 1, 0, 32'h0000_8000, 0);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      bit w;
      bit r;
      int d;
      a = $urandom;
      w = 1'($urandom_range(0, 1));
      r = w ? 1'($urandom_range(0, 1)) : 1'b1;
      d = ($urandom_range(0, 9) == 0) ? TO : int'($urandom_range(0, 4));
      run_op(a, $urandom, w, r, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), d, $urandom, 0);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
